// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Multicycle load/store sequencer between the CPU control FSM and
//            DMEM, with alignment/window checking and fault reporting.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
  parameter logic [31:0] DM_BASE = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] badvaddr,
  output logic        dm_ena,
  output logic        dm_w,
  output logic        dm_r,
  output logic        dm_sign,
  output logic [2:0]  dm_size,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [2:0] c_OP_LB  = 3'b000;
  localparam logic [2:0] c_OP_LH  = 3'b001;
  localparam logic [2:0] c_OP_LW  = 3'b010;
  localparam logic [2:0] c_OP_LHU = 3'b100;
  localparam logic [2:0] c_OP_SH  = 3'b110;
  localparam logic [2:0] c_OP_SW  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_LWAIT  = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_badvaddr;

  logic w_is_half;
  logic w_is_word;
  logic w_fault;
  logic w_q_store;

  // Only the incoming request is checked; latched requests are already legal.
  always_comb begin
    w_is_half = (op == c_OP_LH) || (op == c_OP_LHU) || (op == c_OP_SH);
    w_is_word = (op == c_OP_LW) || (op == c_OP_SW);
    w_fault   = (w_is_half && addr[0]) ||
                (w_is_word && (addr[1:0] != 2'b00)) ||
                (addr[31:12] != DM_BASE[31:12]);
  end

  assign w_q_store = r_op[2] & (r_op[1] | r_op[0]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req) w_state_nxt = w_fault ? S_FAULT : S_ACCESS;
      S_ACCESS: w_state_nxt = w_q_store ? S_DONE : S_LWAIT;
      S_LWAIT:  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      S_FAULT:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 3'b000;
      r_addr     <= 12'h000;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_badvaddr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && req) begin
        r_op    <= op;
        r_addr  <= addr[11:0];
        r_wdata <= wdata;
        if (w_fault) r_badvaddr <= addr;
      end
      if (r_state == S_LWAIT) r_rdata <= dm_rdata;
    end
  end

  // DMEM strobes are decoded from state so reset drops them combinationally.
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    addr_err = (r_state == S_FAULT);
    dm_ena   = 1'b0;
    dm_w     = 1'b0;
    dm_r     = 1'b0;
    dm_sign  = 1'b0;
    dm_size  = 3'b000;
    if (r_state == S_ACCESS) begin
      dm_ena  = 1'b1;
      dm_w    = w_q_store;
      dm_r    = ~w_q_store;
      dm_sign = (r_op == c_OP_LB) || (r_op == c_OP_LH);
      case (r_op)
        c_OP_LH, c_OP_LHU, c_OP_SH: dm_size = 3'b010;
        c_OP_LW, c_OP_SW:           dm_size = 3'b100;
        default:                    dm_size = 3'b001;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign badvaddr = r_badvaddr;
  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed bench for mem_access_unit with a byte-addressed DMEM model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] badvaddr;
  logic        dm_ena;
  logic        dm_w;
  logic        dm_r;
  logic        dm_sign;
  logic [2:0]  dm_size;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  int n_cmp;
  int n_bad;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
    .badvaddr(badvaddr), .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r),
    .dm_sign(dm_sign), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian DMEM with registered, pre-extended read data.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (dm_ena && dm_w) begin
      mem[dm_addr] <= dm_wdata[7:0];
      if (dm_size != 3'b001) mem[dm_addr + 12'd1] <= dm_wdata[15:8];
      if (dm_size == 3'b100) begin
        mem[dm_addr + 12'd2] <= dm_wdata[23:16];
        mem[dm_addr + 12'd3] <= dm_wdata[31:24];
      end
    end
    if (dm_ena && dm_r) begin
      if (dm_size == 3'b001)
        dm_rdata <= {{24{dm_sign & mem[dm_addr][7]}}, mem[dm_addr]};
      else if (dm_size == 3'b010)
        dm_rdata <= {{16{dm_sign & mem[dm_addr + 12'd1][7]}},
                     mem[dm_addr + 12'd1], mem[dm_addr]};
      else
        dm_rdata <= {mem[dm_addr + 12'd3], mem[dm_addr + 12'd2],
                     mem[dm_addr + 12'd1], mem[dm_addr]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] sz);
    issue(o, a, d);
    @(negedge clk);
    check({tag, ".c1_busy"}, {31'b0, busy}, 32'd1);
    check({tag, ".c1_ctl"}, {28'b0, dm_ena, dm_w, dm_r, dm_sign}, 32'b1100);
    check({tag, ".c1_size"}, {29'b0, dm_size}, {29'b0, sz});
    check({tag, ".c1_addr"}, {20'b0, dm_addr}, {20'b0, a[11:0]});
    @(negedge clk);
    check({tag, ".c2_done"}, {29'b0, busy, done, dm_w}, 32'b110);
    @(negedge clk);
    check({tag, ".c3_idle"}, {30'b0, busy, done}, 32'b0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [2:0] sz, input logic sg, input logic [31:0] exp);
    issue(o, a, 32'h0);
    @(negedge clk);
    check({tag, ".c1_ctl"}, {28'b0, dm_ena, dm_w, dm_r, dm_sign}, {28'b0, 3'b101, sg});
    check({tag, ".c1_size"}, {29'b0, dm_size}, {29'b0, sz});
    @(negedge clk);
    check({tag, ".c2_wait"}, {29'b0, busy, done, dm_ena}, 32'b100);
    @(negedge clk);
    check({tag, ".c3_done"}, {30'b0, busy, done}, 32'b11);
    check({tag, ".rdata"}, rdata, exp);
  endtask

  task automatic do_fault(input string tag, input logic [2:0] o, input logic [31:0] a);
    issue(o, a, 32'h5555_5555);
    @(negedge clk);
    check({tag, ".c1"}, {28'b0, busy, addr_err, done, dm_ena}, 32'b1100);
    check({tag, ".bva"}, badvaddr, a);
    @(negedge clk);
    check({tag, ".c2"}, {29'b0, busy, addr_err, dm_ena}, 32'b0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    dm_rdata = 32'h0;
    rst_n = 1'b0; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
    #1;
    check("rst_ctl", {25'b0, busy, done, addr_err, dm_ena, dm_w, dm_r, dm_sign}, 32'b0);
    check("rst_size", {29'b0, dm_size}, 32'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bva", badvaddr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_store("sw", 3'b111, 32'h1001_0004, 32'hDEAD_BEEF, 3'b100);
    do_load ("lw", 3'b010, 32'h1001_0004, 3'b100, 1'b0, 32'hDEAD_BEEF);

    do_store("sb",  3'b101, 32'h1001_0007, 32'h1234_56A5, 3'b001);
    do_load ("lb",  3'b000, 32'h1001_0007, 3'b001, 1'b1, 32'hFFFF_FFA5);
    do_load ("lbu", 3'b011, 32'h1001_0007, 3'b001, 1'b0, 32'h0000_00A5);
    do_load ("lw2", 3'b010, 32'h1001_0004, 3'b100, 1'b0, 32'hA5AD_BEEF);

    do_store("sh",  3'b110, 32'h1001_0002, 32'h0000_8001, 3'b010);
    do_load ("lh",  3'b001, 32'h1001_0002, 3'b010, 1'b1, 32'hFFFF_8001);
    do_load ("lhu", 3'b100, 32'h1001_0002, 3'b010, 1'b0, 32'h0000_8001);
    do_load ("lw0", 3'b010, 32'h1001_0000, 3'b100, 1'b0, 32'h8001_0000);

    do_fault("lh_mis", 3'b001, 32'h1001_0003);
    do_fault("sw_mis", 3'b111, 32'h1001_0006);
    check("rdata_kept", rdata, 32'h8001_0000);
    do_load ("lw_unch", 3'b010, 32'h1001_0004, 3'b100, 1'b0, 32'hA5AD_BEEF);
    do_fault("sw_oow", 3'b111, 32'h1001_1000);

    // req held high across a load: re-accepted only after the state returns to IDLE
    @(negedge clk);
    req = 1'b1; op = 3'b010; addr = 32'h1001_0000;
    @(posedge clk);
    @(negedge clk); check("hold.c1", {30'b0, busy, dm_r}, 32'b11);
    @(negedge clk); check("hold.c2", {30'b0, busy, dm_ena}, 32'b10);
    @(negedge clk); check("hold.c3", {30'b0, busy, done}, 32'b11);
    @(negedge clk); check("hold.c4", {30'b0, busy, dm_ena}, 32'b00);
    @(negedge clk); check("hold.c5", {30'b0, busy, dm_r}, 32'b11);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("hold.end", {31'b0, busy}, 32'b0);

    // asynchronous reset in the middle of a store's ACCESS cycle
    issue(3'b111, 32'h1001_0004, 32'h1111_1111);
    #1;
    check("rst_pre", {30'b0, dm_ena, dm_w}, 32'b11);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {25'b0, busy, done, addr_err, dm_ena, dm_w, dm_r, dm_sign}, 32'b0);
    check("rst_mid_rd", rdata, 32'h0);
    check("rst_mid_bva", badvaddr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_load("lw_after_rst", 3'b010, 32'h1001_0004, 3'b100, 1'b0, 32'hA5AD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle load/store sequencer placed between the CPU control unit and the data memory (`DMEM`). It accepts one memory request at a time from the control FSM and checks alignment and address range. It then drives the DMEM port for exactly one cycle, waits for DMEM's registered read data, and returns the result with a one-cycle `done` pulse. Misaligned or out-of-window accesses never reach DMEM; they raise a one-cycle `addr_err` with the faulting address held for the exception logic.

## Interface

Parameters:
- `DM_BASE`, default `32'h1001_0000`: base of the 4 KiB data window; an address is in range iff `addr[31:12] == DM_BASE[31:12]`.

Ports (clock and reset first):
- `clk`, in, 1: system clock, rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req`, in, 1: request strobe; sampled only in IDLE.
- `op`, in, 3: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- `addr`, in, 32: byte address.
- `wdata`, in, 32: store data; the low byte or halfword is used for SB/SH.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done`, out, 1: one-cycle completion pulse for successful accesses.
- `rdata`, out, 32: load result; valid while `done` is high, held until the next load completes.
- `addr_err`, out, 1: one-cycle fault pulse.
- `badvaddr`, out, 32: faulting address; updated only on a fault.
- `dm_ena`, out, 1: to DMEM `ena`.
- `dm_w`, out, 1: to DMEM `DM_W`.
- `dm_r`, out, 1: to DMEM `DM_R`.
- `dm_sign`, out, 1: to DMEM `DM_sign`.
- `dm_size`, out, 3: to DMEM `DM_size`; one-hot encoding: 001 byte, 010 half, 100 word.
- `dm_addr`, out, 12: to DMEM `DM_addr`, equal to `addr_q[11:0]`.
- `dm_wdata`, out, 32: to DMEM `DM_wdata`, equal to `wdata_q`.
- `dm_rdata`, in, 32: from DMEM `DM_rdata`; already extended by DMEM.

## Operation

- States: IDLE, ACCESS, LWAIT, DONE, FAULT. The encoding is free; all outputs are decoded from registered state and latched request registers.
- **IDLE:** when `req` is high at a rising edge, latch `op_q`, `addr_q` and `wdata_q`.
  - A fault occurs if the address is misaligned (LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0) or out of range. On a fault: `badvaddr <= addr`, go to FAULT.
  - Otherwise go to ACCESS.
- **ACCESS:** `dm_ena`=1.
  - Loads: `dm_r`=1, `dm_w`=0.
  - Stores: `dm_w`=1, `dm_r`=0.
  - `dm_size` is derived from the size of `op_q`. `dm_sign`=1 only for LB/LH.
  - Next state is LWAIT for loads and DONE for stores.
- **LWAIT:** all `dm_*` controls are 0. DMEM read data is valid during this state. At the edge, `rdata <= dm_rdata`, then go to DONE.
- **DONE:** `done`=1, then go to IDLE.
- **FAULT:** `addr_err`=1, then go to IDLE. DMEM is never enabled for a faulting request.
- Outside ACCESS, `dm_ena`, `dm_w`, `dm_r` and `dm_sign` are 0, and `dm_size` is 000. `dm_w` and `dm_r` are never high together.
- `req` is ignored in every state other than IDLE. There is no queueing, and the requester must keep `req` low or re-assert it after `busy` falls.
- `done` and `addr_err` are mutually exclusive.
- Stores do not modify `rdata`. `rdata` is not zero- or sign-extended by this block, because DMEM already extends it.

## Timing

- Reset (async, `rst_n`=0): state goes to IDLE. `busy`, `done`, `addr_err`, `dm_ena`, `dm_w`, `dm_r` and `dm_sign` are 0. `dm_size` is 000. `rdata`, `badvaddr`, `addr_q`, `wdata_q` and `op_q` are 0.
- Reset during ACCESS drops `dm_ena` immediately, so no DMEM write occurs at the following edge. Reset takes effect without waiting for a clock.
- Let E0 be the accepting edge. The first cycle after E0 is cycle 1.
- Store: ACCESS in cycle 1, and DMEM writes at edge E1. `done` is high in cycle 2. `busy` is high in cycles 1–2.
- Load: ACCESS in cycle 1, LWAIT in cycle 2, and `rdata` is captured at E2. `done` is high in cycle 3. `busy` is high in cycles 1–3.
- Fault: `addr_err` and `busy` are high in cycle 1. `badvaddr` is valid from cycle 1 onward.
- Back-to-back: a new `req` is accepted at the edge ending the DONE or FAULT cycle only if the state is IDLE at that edge. Because the state is still DONE/FAULT at that edge, the earliest acceptance is one cycle later. Minimum issue interval: 3 cycles for stores, 4 for loads, 2 for faults.

## Test plan

- SW `wdata`=0xDEADBEEF at 0x10010004, then LW at 0x10010004: expect `dm_w` for exactly one cycle, store `done` in cycle 2, and load `done` in cycle 3 with `rdata`=0xDEADBEEF.
- SB 0x123456A5 at 0x10010007, then LB and LBU at 0x10010007: expect 0xFFFFFFA5 and 0x000000A5. A following LW at 0x10010004 returns 0xA5ADBEEF.
- SH 0x00008001 at 0x10010002, then LH and LHU at 0x10010002: expect 0xFFFF8001 and 0x00008001. A following LW at 0x10010000 is consistent with the prior contents.
- LH at 0x10010003 and SW at 0x10010006: expect `addr_err` for one cycle, `badvaddr` = the request address, `dm_ena` never asserted, and memory unchanged.
- SW at 0x10011000 (out of window): expect a fault with `badvaddr`=0x10011000. `req` held high through a load's busy period is not re-accepted until IDLE.
- Assert `rst_n`=0 mid-cycle during ACCESS of an SW: expect all outputs to be 0 immediately, and a later LW of that address returns the old value.
